// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch alignment engine.
//   - FSM state encoding (IDLE/INIT/FILL/TRACE)
//   - traceback op codes streamed to the alignment printer
//   - direction codes stored per matrix cell
//   - default score constants for callers that want the classic +1/-1/-2 set
package nw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        FILL  = 2'd2,
        TRACE = 2'd3
    } state_t;

    localparam logic [1:0] OP_MATCH = 2'd0;
    localparam logic [1:0] OP_MISM  = 2'd1;
    localparam logic [1:0] OP_GAPB  = 2'd2;  // up: consumes a symbol of A
    localparam logic [1:0] OP_GAPA  = 2'd3;  // left: consumes a symbol of B

    localparam logic [1:0] DIR_DIAG = 2'd0;
    localparam logic [1:0] DIR_UP   = 2'd1;
    localparam logic [1:0] DIR_LEFT = 2'd2;
    localparam logic [1:0] DIR_STOP = 2'd3;

    localparam int DEF_MATCH = 1;
    localparam int DEF_MISM  = -1;
    localparam int DEF_GAP   = -2;

endpackage

// File: rtl/nw_cell_max.sv
// nw_cell_max: combinational score for one dynamic-programming cell.
// Three saturating adds (diag + substitution, up + gap, left + gap) followed
// by a priority max3 with ties resolved DIAG > UP > LEFT.
// Ports:
//   s_diag, s_up, s_left  in   neighbour scores S(i-1,j-1), S(i-1,j), S(i,j-1)
//   sub_score             in   match or mismatch score for this cell
//   gap_score             in   gap score
//   s_best                out  winning score
//   dir_best              out  direction code of the winner
module nw_cell_max
    import nw_pkg::*;
#(
    parameter int SCORE_W = 9
) (
    input  logic signed [SCORE_W-1:0] s_diag,
    input  logic signed [SCORE_W-1:0] s_up,
    input  logic signed [SCORE_W-1:0] s_left,
    input  logic signed [SCORE_W-1:0] sub_score,
    input  logic signed [SCORE_W-1:0] gap_score,
    output logic signed [SCORE_W-1:0] s_best,
    output logic        [1:0]         dir_best
);

    localparam logic signed [SCORE_W-1:0] SAT_MAX = {1'b0, {(SCORE_W-1){1'b1}}};
    localparam logic signed [SCORE_W-1:0] SAT_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

    // One guard bit catches overflow; disagreeing top bits mean out of range.
    function automatic logic signed [SCORE_W-1:0] sat_add(
        input logic signed [SCORE_W-1:0] x,
        input logic signed [SCORE_W-1:0] y
    );
        logic [SCORE_W:0] s;
        s = {x[SCORE_W-1], x} + {y[SCORE_W-1], y};
        if (s[SCORE_W] != s[SCORE_W-1])
            return s[SCORE_W] ? SAT_MIN : SAT_MAX;
        return s[SCORE_W-1:0];
    endfunction

    logic signed [SCORE_W-1:0] d, u, l;

    always_comb begin
        d = sat_add(s_diag, sub_score);
        u = sat_add(s_up, gap_score);
        l = sat_add(s_left, gap_score);
        if (d >= u && d >= l) begin
            s_best   = d;
            dir_best = DIR_DIAG;
        end else if (u >= l) begin
            s_best   = u;
            dir_best = DIR_UP;
        end else begin
            s_best   = l;
            dir_best = DIR_LEFT;
        end
    end

endmodule

// File: rtl/nw_align_engine.sv
// nw_align_engine: self-sequenced Needleman-Wunsch aligner.
// IDLE -> INIT (N+1 cycles, borders) -> FILL (N*N cycles, row-major)
// -> TRACE (one op per handshake) -> IDLE. Score/direction matrices live in
// registers. Optional macro LOCAL_ALIGN_EN selects Smith-Waterman mode
// (zero-clamped scores, STOP cells, traceback from the first maximum).
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start                  begin alignment (accepted in IDLE only)
//   seq_a, seq_b           packed sequences, symbol k at [k*SYM_W-1 -: SYM_W]
//   match/mism/gap_score   signed scores latched with the sequences
//   busy                   high in INIT/FILL/TRACE
//   done                   one-cycle pulse after the last op transfers
//   final_score            score at the traceback origin
//   out_valid/out_ready    op stream handshake
//   out_op, out_i, out_j   op code and the cell it leaves
//   out_last               final op of the alignment
module nw_align_engine
    import nw_pkg::*;
#(
    parameter  int N       = 3,
    parameter  int SYM_W   = 2,
    parameter  int SCORE_W = 9,
    localparam int IW      = $clog2(N + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [N*SYM_W-1:0]        seq_a,
    input  logic [N*SYM_W-1:0]        seq_b,
    input  logic signed [SCORE_W-1:0] match_score,
    input  logic signed [SCORE_W-1:0] mism_score,
    input  logic signed [SCORE_W-1:0] gap_score,
    output logic                      busy,
    output logic                      done,
    output logic signed [SCORE_W-1:0] final_score,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [1:0]                out_op,
    output logic [IW-1:0]             out_i,
    output logic [IW-1:0]             out_j,
    output logic                      out_last
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N);
    localparam logic [IW-1:0] ONE      = IW'(1);

    state_t state, state_nx;

    logic [N*SYM_W-1:0]        a_r, b_r;
    logic signed [SCORE_W-1:0] match_r, mism_r, gap_r;
    logic signed [SCORE_W-1:0] s_mat   [0:N][0:N];
    logic [1:0]                dir_mat [0:N][0:N];
    logic [IW-1:0]             k, fi, fj, ti, tj;

`ifdef LOCAL_ALIGN_EN
    logic signed [SCORE_W-1:0] best_val;
    logic [IW-1:0]             best_i, best_j;
    logic                      better;
`else
    logic signed [SCORE_W-1:0] init_acc;
`endif

    localparam logic signed [SCORE_W-1:0] SAT_MAX = {1'b0, {(SCORE_W-1){1'b1}}};
    localparam logic signed [SCORE_W-1:0] SAT_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

    function automatic logic signed [SCORE_W-1:0] sat_add(
        input logic signed [SCORE_W-1:0] x,
        input logic signed [SCORE_W-1:0] y
    );
        logic [SCORE_W:0] s;
        s = {x[SCORE_W-1], x} + {y[SCORE_W-1], y};
        if (s[SCORE_W] != s[SCORE_W-1])
            return s[SCORE_W] ? SAT_MIN : SAT_MAX;
        return s[SCORE_W-1:0];
    endfunction

    // 1-based symbol lookup; index 0 (a border row/column) yields 0.
    function automatic logic [SYM_W-1:0] sym_at(
        input logic [N*SYM_W-1:0] seq,
        input logic [IW-1:0]      idx
    );
        logic [SYM_W-1:0] r;
        r = '0;
        for (int p = 1; p <= N; p++)
            if (idx == IW'(p)) r = seq[p*SYM_W-1 -: SYM_W];
        return r;
    endfunction

    // Fill datapath: one cell per cycle through the shared cell-max unit.
    logic [IW-1:0]             fi_m1, fj_m1;
    logic signed [SCORE_W-1:0] cm_diag, cm_up, cm_left, cm_sub, cell_s, fill_val;
    logic [1:0]                cell_dir, fill_dir;

    always_comb begin
        fi_m1   = fi - ONE;
        fj_m1   = fj - ONE;
        cm_diag = s_mat[fi_m1][fj_m1];
        cm_up   = s_mat[fi_m1][fj];
        cm_left = s_mat[fi][fj_m1];
        cm_sub  = (sym_at(a_r, fi) == sym_at(b_r, fj)) ? match_r : mism_r;
    end

    nw_cell_max #(.SCORE_W(SCORE_W)) u_cell (
        .s_diag    (cm_diag),
        .s_up      (cm_up),
        .s_left    (cm_left),
        .sub_score (cm_sub),
        .gap_score (gap_r),
        .s_best    (cell_s),
        .dir_best  (cell_dir)
    );

    always_comb begin
`ifdef LOCAL_ALIGN_EN
        // Non-positive results clamp to 0 and end any traceback through them.
        if (!cell_s[SCORE_W-1] && cell_s != '0) begin
            fill_val = cell_s;
            fill_dir = cell_dir;
        end else begin
            fill_val = '0;
            fill_dir = DIR_STOP;
        end
        // Strictly greater keeps the first maximum in row-major order.
        better = (fill_val > best_val);
`else
        fill_val = cell_s;
        fill_dir = cell_dir;
`endif
    end

    // Traceback step from (ti,tj): border rows/columns force the move.
    logic [1:0]    cur_dir, mv, tr_op;
    logic [IW-1:0] ni, nj;
    logic          tr_last;

    always_comb begin
        cur_dir = dir_mat[ti][tj];
        if (ti == '0)      mv = DIR_LEFT;
        else if (tj == '0) mv = DIR_UP;
        else               mv = cur_dir;
        case (mv)
            DIR_UP: begin
                tr_op = OP_GAPB;
                ni    = ti - ONE;
                nj    = tj;
            end
            DIR_LEFT: begin
                tr_op = OP_GAPA;
                ni    = ti;
                nj    = tj - ONE;
            end
            default: begin
                tr_op = (sym_at(a_r, ti) == sym_at(b_r, tj)) ? OP_MATCH : OP_MISM;
                ni    = ti - ONE;
                nj    = tj - ONE;
            end
        endcase
`ifdef LOCAL_ALIGN_EN
        tr_last = (cur_dir == DIR_STOP) || (dir_mat[ni][nj] == DIR_STOP);
`else
        tr_last = (ni == '0) && (nj == '0);
`endif
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = INIT;
            INIT:  if (k == LAST_IDX) state_nx = FILL;
            FILL:  if (fi == LAST_IDX && fj == LAST_IDX) state_nx = TRACE;
            TRACE: if (out_valid && out_ready && out_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done        <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_op      <= '0;
            out_i       <= '0;
            out_j       <= '0;
            final_score <= '0;
            k           <= '0;
            fi          <= '0;
            fj          <= '0;
            ti          <= '0;
            tj          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r      <= seq_a;
                        b_r      <= seq_b;
                        match_r  <= match_score;
                        mism_r   <= mism_score;
                        gap_r    <= gap_score;
                        k        <= '0;
`ifndef LOCAL_ALIGN_EN
                        init_acc <= '0;
`endif
                    end
                end
                // Border k of both row 0 and column 0 per cycle.
                INIT: begin
`ifdef LOCAL_ALIGN_EN
                    s_mat[k][0]   <= '0;
                    s_mat[0][k]   <= '0;
                    dir_mat[k][0] <= DIR_STOP;
                    dir_mat[0][k] <= DIR_STOP;
                    best_val      <= '0;
                    best_i        <= LAST_IDX;
                    best_j        <= LAST_IDX;
`else
                    // Running saturated sum equals the saturated k*gap.
                    s_mat[k][0]   <= init_acc;
                    s_mat[0][k]   <= init_acc;
                    dir_mat[k][0] <= DIR_UP;
                    dir_mat[0][k] <= DIR_LEFT;
                    init_acc      <= sat_add(init_acc, gap_r);
`endif
                    k  <= k + ONE;
                    fi <= ONE;
                    fj <= ONE;
                end
                // One interior cell per cycle, row-major.
                FILL: begin
                    s_mat[fi][fj]   <= fill_val;
                    dir_mat[fi][fj] <= fill_dir;
                    if (fj == LAST_IDX) begin
                        fj <= ONE;
                        fi <= fi + ONE;
                    end else begin
                        fj <= fj + ONE;
                    end
`ifdef LOCAL_ALIGN_EN
                    if (better) begin
                        best_val <= fill_val;
                        best_i   <= fi;
                        best_j   <= fj;
                    end
                    ti <= better ? fi : best_i;
                    tj <= better ? fj : best_j;
`else
                    ti <= LAST_IDX;
                    tj <= LAST_IDX;
`endif
                end
                // Present the op at (ti,tj) and step the pointer to its destination.
                TRACE: begin
                    if (out_valid && out_ready && out_last) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                    end else if (!out_valid || out_ready) begin
                        if (!out_valid) final_score <= s_mat[ti][tj];
                        out_valid <= 1'b1;
                        out_op    <= tr_op;
                        out_i     <= ti;
                        out_j     <= tj;
                        out_last  <= tr_last;
                        ti        <= ni;
                        tj        <= nj;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nw_align_engine.sv
// Self-checking bench for nw_align_engine (N=3, SYM_W=2, SCORE_W=9).
// A behavioural model computes the full score matrix with integer arithmetic
// and clamping, then walks the traceback into a queue of expected ops. A single
// compare process checks every presented op against the queue head.
module tb_nw_align_engine;
    import nw_pkg::*;

    localparam int N       = 3;
    localparam int SYM_W   = 2;
    localparam int SCORE_W = 9;
    localparam int IW      = 2;
    localparam int SMAX    = 255;
    localparam int SMIN    = -256;
    localparam int LAT     = N + 1 + N * N + 1;

    logic                      clk;
    logic                      rst;
    logic                      start;
    logic [N*SYM_W-1:0]        seq_a, seq_b;
    logic signed [SCORE_W-1:0] match_score, mism_score, gap_score;
    logic                      busy, done, out_valid, out_ready, out_last;
    logic signed [SCORE_W-1:0] final_score;
    logic [1:0]                out_op;
    logic [IW-1:0]             out_i, out_j;

    nw_align_engine #(.N(N), .SYM_W(SYM_W), .SCORE_W(SCORE_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .seq_a       (seq_a),
        .seq_b       (seq_b),
        .match_score (match_score),
        .mism_score  (mism_score),
        .gap_score   (gap_score),
        .busy        (busy),
        .done        (done),
        .final_score (final_score),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_i       (out_i),
        .out_j       (out_j),
        .out_last    (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int op;
        int i;
        int j;
        int last;
    } op_t;

    op_t expq[$];
    int  exp_final;
    int  ms [0:N][0:N];
    int  md [0:N][0:N];   // 0 diag, 1 up, 2 left, 3 stop

    function automatic int clampv(input int v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    function automatic int sym(input logic [N*SYM_W-1:0] s, input int k);
        return int'((s >> (SYM_W * (k - 1))) & 3);
    endfunction

    task automatic build_model(input logic [N*SYM_W-1:0] a, b, input int m, x, g);
        int d, u, l, v, dir, bi, bj, bv, i, j, ni, nj, cur, lst;
        op_t e;
        expq.delete();
        bv = 0; bi = N; bj = N;
        for (int q = 0; q <= N; q++) begin
`ifdef LOCAL_ALIGN_EN
            ms[q][0] = 0; ms[0][q] = 0; md[q][0] = 3; md[0][q] = 3;
`else
            ms[q][0] = clampv(q * g); ms[0][q] = clampv(q * g);
            md[q][0] = 1; md[0][q] = 2;
`endif
        end
        for (int r = 1; r <= N; r++)
            for (int c = 1; c <= N; c++) begin
                d = clampv(ms[r-1][c-1] + ((sym(a, r) == sym(b, c)) ? m : x));
                u = clampv(ms[r-1][c] + g);
                l = clampv(ms[r][c-1] + g);
                if (d >= u && d >= l) begin v = d; dir = 0; end
                else if (u >= l)      begin v = u; dir = 1; end
                else                  begin v = l; dir = 2; end
`ifdef LOCAL_ALIGN_EN
                if (v <= 0) begin v = 0; dir = 3; end
                if (v > bv) begin bv = v; bi = r; bj = c; end
`endif
                ms[r][c] = v;
                md[r][c] = dir;
            end
`ifdef LOCAL_ALIGN_EN
        i = bi; j = bj; exp_final = bv;
`else
        i = N; j = N; exp_final = ms[N][N];
`endif
        for (int step = 0; step < 2 * N; step++) begin
            cur = md[i][j];
            if (i == 0)      cur = 2;
            else if (j == 0) cur = 1;
            if (cur == 1)      begin e.op = OP_GAPB; ni = i - 1; nj = j;     end
            else if (cur == 2) begin e.op = OP_GAPA; ni = i;     nj = j - 1; end
            else begin
                e.op = (sym(a, i) == sym(b, j)) ? OP_MATCH : OP_MISM;
                ni = i - 1; nj = j - 1;
            end
`ifdef LOCAL_ALIGN_EN
            lst = (md[i][j] == 3 || md[ni][nj] == 3) ? 1 : 0;
`else
            lst = (ni == 0 && nj == 0) ? 1 : 0;
`endif
            e.i = i; e.j = j; e.last = lst;
            expq.push_back(e);
            i = ni; j = nj;
            if (lst == 1) break;
        end
    endtask

    // ---------------- compare process ----------------
    bit chk_en = 1'b0;
    int ops_seen, done_seen;

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            if (out_valid) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL extra_op: got op %0d at (%0d,%0d), expected no op", out_op, out_i, out_j);
                end else begin
                    check("out_op", out_op, expq[0].op);
                    check("out_i", out_i, expq[0].i);
                    check("out_j", out_j, expq[0].j);
                    check("out_last", out_last, expq[0].last);
                    check("final_score", final_score, exp_final);
                    if (out_ready) begin
                        void'(expq.pop_front());
                        ops_seen++;
                    end
                end
            end
            if (done) begin
                check("done_ops_left", expq.size(), 0);
                check("done_busy", busy, 0);
                check("done_out_valid", out_valid, 0);
                done_seen++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_scores(input int m, x, g);
        match_score = SCORE_W'(m);
        mism_score  = SCORE_W'(x);
        gap_score   = SCORE_W'(g);
    endtask

    // Called and returns at #1 after a rising edge.
    task automatic run_case(input logic [N*SYM_W-1:0] a, b, input int m, x, g,
                            input int stall0, input bit rnd, input bit mid_start);
        int n_exp, lat, cyc, stall;
        build_model(a, b, m, x, g);
        n_exp = expq.size();
        ops_seen = 0; done_seen = 0;
        out_ready = 1'b0;
        seq_a = a; seq_b = b; drive_scores(m, x, g);
        start = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seq_a = N*SYM_W'($urandom); seq_b = N*SYM_W'($urandom);
        drive_scores(int'($urandom_range(0, 20)) - 10, int'($urandom_range(0, 20)) - 10, -1);
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (mid_start && lat == 7) begin
                start = 1'b1; seq_a = ~a; seq_b = ~b; drive_scores(5, 5, 5);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("first_valid_latency", lat, LAT);
        cyc = 0; stall = stall0;
        while (!done && cyc < 100) begin
            out_ready = (stall > 0) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            if (stall > 0) stall--;
            @(posedge clk); #1;
            cyc++;
        end
        check("done_reached", done, 1);
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("done_is_pulse", done, 0);
        check("busy_after_done", busy, 0);
        check("ops_transferred", ops_seen, n_exp);
        check("done_pulses", done_seen, 1);
        chk_en = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_out_op"}, out_op, 0);
        check({tag, "_out_i"}, out_i, 0);
        check({tag, "_out_j"}, out_j, 0);
        check({tag, "_final_score"}, final_score, 0);
    endtask

    localparam logic [5:0] S_ACG = {2'd2, 2'd1, 2'd0};
    localparam logic [5:0] S_AAA = 6'b00_00_00;
    localparam logic [5:0] S_CCC = 6'b01_01_01;
    localparam logic [5:0] S_TAC = {2'd1, 2'd0, 2'd3};
    localparam logic [5:0] S_GAC = {2'd1, 2'd0, 2'd2};

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        seq_a = '0; seq_b = '0;
        drive_scores(DEF_MATCH, DEF_MISM, DEF_GAP);
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        @(posedge clk); #1;

`ifndef LOCAL_ALIGN_EN
        // Model pins for the two reference alignments.
        build_model(S_ACG, S_ACG, DEF_MATCH, DEF_MISM, DEF_GAP);
        check("pin1_final", exp_final, 3);
        check("pin1_nops", expq.size(), 3);
        for (int q = 0; q < 3; q++) begin
            check("pin1_op", expq[q].op, OP_MATCH);
            check("pin1_i", expq[q].i, 3 - q);
            check("pin1_j", expq[q].j, 3 - q);
            check("pin1_last", expq[q].last, (q == 2) ? 1 : 0);
        end
        build_model(S_AAA, S_CCC, DEF_MATCH, DEF_MISM, DEF_GAP);
        check("pin2_final", exp_final, -3);
        check("pin2_s12", ms[1][2], -3);
        check("pin2_dir12_diag", md[1][2], 0);
        check("pin2_op0", expq[0].op, OP_MISM);
`else
        build_model(S_TAC, S_GAC, DEF_MATCH, DEF_MISM, DEF_GAP);
        check("pin6_final", exp_final, 2);
        check("pin6_nops", expq.size(), 2);
        check("pin6_i1", expq[1].i, 2);
        check("pin6_last1", expq[1].last, 1);
`endif

        // Reference alignments, stalled first op, start ignored mid-FILL.
        run_case(S_ACG, S_ACG, DEF_MATCH, DEF_MISM, DEF_GAP, 0, 1'b0, 1'b0);
        check("case1_final", final_score, exp_final);
        run_case(S_AAA, S_CCC, DEF_MATCH, DEF_MISM, DEF_GAP, 0, 1'b0, 1'b0);
        run_case(S_ACG, S_ACG, DEF_MATCH, DEF_MISM, DEF_GAP, 5, 1'b0, 1'b0);
        check("case3_nops", ops_seen, 3);
        run_case(S_ACG, S_CCC, DEF_MATCH, DEF_MISM, DEF_GAP, 0, 1'b0, 1'b1);
        run_case(S_TAC, S_GAC, DEF_MATCH, DEF_MISM, DEF_GAP, 0, 1'b1, 1'b0);

        // Reset in FILL cycle 4 aborts the run.
        seq_a = S_ACG; seq_b = S_ACG; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_values("abort");
        run_case(S_AAA, S_CCC, DEF_MATCH, DEF_MISM, DEF_GAP, 0, 1'b0, 1'b0);

        // Saturating scores.
        run_case(S_AAA, S_AAA, 200, -200, -120, 0, 1'b1, 1'b0);
        run_case(S_ACG, S_CCC, -100, -200, -250, 0, 1'b1, 1'b0);

        // Randomized alignments with random backpressure.
        for (int r = 0; r < 20; r++) begin
            run_case(N*SYM_W'($urandom), N*SYM_W'($urandom),
                     int'($urandom_range(0, 8)) - 2,
                     int'($urandom_range(0, 8)) - 6,
                     int'($urandom_range(0, 6)) - 5,
                     int'($urandom_range(0, 2)), 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
